// File: rtl/imem_line_server.sv
// Instruction-memory line server: answers a cache line request with four
// 32-bit words read from a preloadable backing store after a fixed latency.
module imem_line_server #(
    parameter int LINE_BITS = 16,
    parameter int MEM_WORDS = 4096,
    parameter int LATENCY   = 3
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 Ic_mem_req,
    input  logic [LINE_BITS-1:0] Ic_mem_addr,
    output logic [127:0]         F_mem_inst,
    output logic                 F_mem_valid,
    output logic                 busy,
    input  logic                 ld_en,
    input  logic [LINE_BITS+1:0] ld_addr,
    input  logic [31:0]          ld_data
);

    localparam int         AW   = $clog2(MEM_WORDS);
    localparam logic [3:0] LAT4 = 4'(LATENCY);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WAIT  = 2'd1,
        FETCH = 2'd2,
        RESP  = 2'd3
    } state_t;

    state_t                 state_q, state_d;
    logic [LINE_BITS-1:0]   line_q, line_d;
    logic [3:0]             cnt_q, cnt_d;
    logic [1:0]             beat_q, beat_d;
    logic [95:0]            lbuf_q, lbuf_d;
    logic [127:0]           inst_q, inst_d;
    logic                   valid_q, valid_d;
    logic                   busy_q, busy_d;

    logic [31:0]            mem [MEM_WORDS];
    logic [LINE_BITS+1:0]   fetch_addr_s;
    logic [31:0]            rd_word_s;
    logic                   unused_s;

    assign fetch_addr_s = {line_q, beat_q};
    assign rd_word_s    = mem[fetch_addr_s[AW-1:0]];
    assign unused_s     = ^{ld_addr, fetch_addr_s};

    assign F_mem_inst  = inst_q;
    assign F_mem_valid = valid_q;
    assign busy        = busy_q;

    // Next-state and datapath logic for the request FSM.
    always_comb begin
        state_d = state_q;
        line_d  = line_q;
        cnt_d   = cnt_q;
        beat_d  = beat_q;
        lbuf_d  = lbuf_q;
        inst_d  = inst_q;
        valid_d = 1'b0;
        case (state_q)
            IDLE: begin
                if (Ic_mem_req) begin
                    line_d = Ic_mem_addr;
                    beat_d = 2'd0;
                    if (LATENCY == 0) begin
                        state_d = FETCH;
                        cnt_d   = 4'd0;
                    end else begin
                        state_d = WAIT;
                        cnt_d   = LAT4;
                    end
                end else begin
                    state_d = IDLE;
                end
            end
            WAIT: begin
                if (cnt_q <= 4'd1) begin
                    state_d = FETCH;
                    cnt_d   = 4'd0;
                    beat_d  = 2'd0;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            FETCH: begin
                // The last beat goes straight into the output line so the
                // response is ready in the same edge that enters RESP.
                case (beat_q)
                    2'd0:    lbuf_d[31:0]  = rd_word_s;
                    2'd1:    lbuf_d[63:32] = rd_word_s;
                    2'd2:    lbuf_d[95:64] = rd_word_s;
                    default: lbuf_d        = lbuf_q;
                endcase
                if (beat_q == 2'd3) begin
                    inst_d  = {rd_word_s, lbuf_q};
                    valid_d = 1'b1;
                    state_d = RESP;
                    beat_d  = 2'd0;
                end else begin
                    beat_d = beat_q + 2'd1;
                end
            end
            RESP: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
        busy_d = (state_d != IDLE);
    end

    // State and output registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= IDLE;
            line_q  <= '0;
            cnt_q   <= 4'd0;
            beat_q  <= 2'd0;
            lbuf_q  <= '0;
            inst_q  <= '0;
            valid_q <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            line_q  <= line_d;
            cnt_q   <= cnt_d;
            beat_q  <= beat_d;
            lbuf_q  <= lbuf_d;
            inst_q  <= inst_d;
            valid_q <= valid_d;
            busy_q  <= busy_d;
        end
    end

    // Backing store preload port; contents survive reset.
    always_ff @(posedge clk) begin
        if (ld_en && (state_q == IDLE)) begin
            mem[ld_addr[AW-1:0]] <= ld_data;
        end
    end

endmodule

// File: tb/tb_imem_line_server.sv
// Directed bench for imem_line_server: table of line requests plus
// hand-written sequences for back-to-back, mid-flight and reset corners.
module tb_imem_line_server;

    localparam int LAT = 3;

    logic         clk = 1'b0;
    logic         rst;
    logic         req0, ld0_en;
    logic [15:0]  addr0;
    logic [17:0]  ld0_addr;
    logic [31:0]  ld0_data;
    logic [127:0] inst0;
    logic         valid0, busy0;
    logic         req1, ld1_en;
    logic [15:0]  addr1;
    logic [17:0]  ld1_addr;
    logic [31:0]  ld1_data;
    logic [127:0] inst1;
    logic         valid1, busy1;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    typedef struct {
        int           cyc;
        logic [127:0] data;
    } pulse_t;
    pulse_t pq0[$];
    pulse_t pq1[$];

    typedef struct {
        logic [15:0]  addr;
        logic [127:0] exp;
        string        name;
    } vec_t;

    imem_line_server #(.LINE_BITS(16), .MEM_WORDS(4096), .LATENCY(LAT)) dut0 (
        .clk(clk), .rst(rst), .Ic_mem_req(req0), .Ic_mem_addr(addr0),
        .F_mem_inst(inst0), .F_mem_valid(valid0), .busy(busy0),
        .ld_en(ld0_en), .ld_addr(ld0_addr), .ld_data(ld0_data)
    );

    imem_line_server #(.LINE_BITS(16), .MEM_WORDS(4096), .LATENCY(0)) dut1 (
        .clk(clk), .rst(rst), .Ic_mem_req(req1), .Ic_mem_addr(addr1),
        .F_mem_inst(inst1), .F_mem_valid(valid1), .busy(busy1),
        .ld_en(ld1_en), .ld_addr(ld1_addr), .ld_data(ld1_data)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        pulse_t p;
        p.cyc = cyc;
        if (valid0) begin
            p.data = inst0;
            pq0.push_back(p);
        end
        if (valid1) begin
            p.data = inst1;
            pq1.push_back(p);
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(string name, logic [127:0] act, logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %h want %h", name, act, exp);
        end
    endtask

    task automatic preload(logic [17:0] a, logic [31:0] d);
        ld0_en   = 1'b1;
        ld0_addr = a;
        ld0_data = d;
        tick();
        ld0_en   = 1'b0;
    endtask

    task automatic check_resp(int c0, logic [127:0] exp, string name);
        while (cyc < c0 + LAT + 8) tick();
        chk({name, "_npulse"}, 128'(pq0.size()), 128'd1);
        if (pq0.size() > 0) begin
            chk({name, "_lat"}, 128'(pq0[0].cyc - c0), 128'(LAT + 4));
            chk({name, "_data"}, pq0[0].data, exp);
        end
        chk({name, "_hold"}, inst0, exp);
        chk({name, "_vlow"}, 128'(valid0), 128'd0);
    endtask

    task automatic do_req(logic [15:0] a, logic [127:0] exp, string name);
        int c0;
        pq0.delete();
        req0  = 1'b1;
        addr0 = a;
        tick();
        c0   = cyc;
        req0 = 1'b0;
        check_resp(c0, exp, name);
    endtask

    initial begin
        vec_t         vt[6];
        int           c0;
        logic [127:0] l0, l5, l6, l9, lf;

        l0 = {32'h00000044, 32'h00000033, 32'h00000022, 32'h00000011};
        l5 = {32'h50000003, 32'h50000002, 32'h50000001, 32'h50000000};
        l6 = {32'h60000003, 32'h60000002, 32'h60000001, 32'h60000000};
        l9 = {32'h90000003, 32'h90000002, 32'h90000001, 32'h90000000};
        lf = {32'hF0000003, 32'hF0000002, 32'hF0000001, 32'hF0000000};
        vt[0] = '{16'h0000, l0, "line0"};
        vt[1] = '{16'h0005, l5, "line5"};
        vt[2] = '{16'h0009, l9, "line9"};
        vt[3] = '{16'h0400, l0, "wrap0"};
        vt[4] = '{16'h0405, l5, "wrap5"};
        vt[5] = '{16'hFFFF, lf, "top"};

        rst = 1'b0;
        req0 = 1'b0; addr0 = 16'd0; ld0_en = 1'b0; ld0_addr = 18'd0; ld0_data = 32'd0;
        req1 = 1'b0; addr1 = 16'd0; ld1_en = 1'b0; ld1_addr = 18'd0; ld1_data = 32'd0;
        repeat (3) tick();
        chk("rst_busy", 128'(busy0), 128'd0);
        chk("rst_valid", 128'(valid0), 128'd0);
        chk("rst_inst", inst0, 128'd0);
        rst = 1'b1;
        tick();

        preload(18'd0, 32'h00000011);
        preload(18'd1, 32'h00000022);
        preload(18'd2, 32'h00000033);
        preload(18'd3, 32'h00000044);
        for (int k = 0; k < 4; k++) begin
            preload(18'(20 + k), 32'h50000000 + 32'(k));
            preload(18'(24 + k), 32'h60000000 + 32'(k));
            preload(18'(36 + k), 32'h90000000 + 32'(k));
            preload(18'(4092 + k), 32'hF0000000 + 32'(k));
        end

        for (int i = 0; i < 6; i++) begin
            do_req(vt[i].addr, vt[i].exp, vt[i].name);
        end

        // Held request for line 5, switched to line 6 during the response.
        pq0.delete();
        req0 = 1'b1; addr0 = 16'd5;
        tick();
        c0 = cyc;
        repeat (LAT + 4) tick();
        addr0 = 16'd6;
        tick();
        tick();
        req0 = 1'b0;
        while (cyc < c0 + 2 * LAT + 14) tick();
        chk("b2b_npulse", 128'(pq0.size()), 128'd2);
        if (pq0.size() == 2) begin
            chk("b2b_lat", 128'(pq0[0].cyc - c0), 128'(LAT + 4));
            chk("b2b_gap", 128'(pq0[1].cyc - pq0[0].cyc), 128'(LAT + 6));
            chk("b2b_data0", pq0[0].data, l5);
            chk("b2b_data1", pq0[1].data, l6);
        end

        // Request changes during WAIT must not disturb the transaction.
        pq0.delete();
        req0 = 1'b1; addr0 = 16'd0;
        tick();
        c0 = cyc;
        req0 = 1'b0;
        tick();
        req0 = 1'b1; addr0 = 16'd9;
        tick();
        tick();
        req0 = 1'b0;
        check_resp(c0, l0, "midchg");

        // Preload while busy is dropped; an idle preload takes effect.
        pq0.delete();
        req0 = 1'b1; addr0 = 16'd5;
        tick();
        c0 = cyc;
        req0 = 1'b0;
        tick();
        ld0_en = 1'b1; ld0_addr = 18'd20; ld0_data = 32'hDEADBEEF;
        tick();
        ld0_en = 1'b0;
        check_resp(c0, l5, "busyld");
        preload(18'd20, 32'hDEADBEEF);
        do_req(16'd5, {32'h50000003, 32'h50000002, 32'h50000001, 32'hDEADBEEF}, "idleld");

        // Preload and request accepted in the same idle cycle.
        pq0.delete();
        req0 = 1'b1; addr0 = 16'd5;
        ld0_en = 1'b1; ld0_addr = 18'd21; ld0_data = 32'h12345678;
        tick();
        c0 = cyc;
        req0 = 1'b0; ld0_en = 1'b0;
        check_resp(c0, {32'h50000003, 32'h50000002, 32'h12345678, 32'hDEADBEEF}, "sameld");

        // Reset during FETCH abandons the transaction.
        pq0.delete();
        req0 = 1'b1; addr0 = 16'd9;
        tick();
        req0 = 1'b0;
        repeat (4) tick();
        rst = 1'b0;
        tick();
        chk("frst_busy", 128'(busy0), 128'd0);
        chk("frst_valid", 128'(valid0), 128'd0);
        chk("frst_inst", inst0, 128'd0);
        rst = 1'b1;
        repeat (12) tick();
        chk("frst_nopulse", 128'(pq0.size()), 128'd0);
        do_req(16'd0, l0, "postrst");

        // Zero-latency instance, highest line index.
        for (int k = 0; k < 4; k++) begin
            ld1_en = 1'b1; ld1_addr = 18'(4092 + k); ld1_data = 32'hC0000000 + 32'(k);
            tick();
        end
        ld1_en = 1'b0;
        pq1.delete();
        req1 = 1'b1; addr1 = 16'hFFFF;
        tick();
        c0 = cyc;
        req1 = 1'b0;
        while (cyc < c0 + 10) tick();
        chk("lat0_npulse", 128'(pq1.size()), 128'd1);
        if (pq1.size() > 0) begin
            chk("lat0_lat", 128'(pq1[0].cyc - c0), 128'd4);
            chk("lat0_data", pq1[0].data,
                {32'hC0000003, 32'hC0000002, 32'hC0000001, 32'hC0000000});
        end
        chk("lat0_busy", 128'(busy1), 128'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
